// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered reads and a per-register busy scoreboard.
// Optional macro REGFILE_WRITE_BYPASS_EN selects write-first reads (default: read-first).
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*$clog2(NREGS)-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 rsv_en,
  input  logic [$clog2(NREGS)-1:0] rsv_addr,
  input  logic [NRD-1:0]       rd_req,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_valid,
  output logic [NRD-1:0]       rd_busy,
  output logic [NREGS-1:0]     busy_vec
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic [NREGS-1:0]           r_busy;
  logic [NREGS-1:0][XLEN-1:0] w_regs_nxt;
  logic [NREGS-1:0]           w_busy_nxt;
  logic [NREGS-1:0][XLEN-1:0] w_src_regs;
  logic [NREGS-1:0]           w_src_busy;

  logic [NRD*XLEN-1:0] r_rd_data;
  logic [NRD-1:0]      r_rd_valid;
  logic [NRD-1:0]      r_rd_busy;

  // Next-state array: writes in ascending port order so the highest port wins,
  // then a reservation overrides the busy clear from a same-cycle write.
  always_comb begin
    w_regs_nxt = r_regs;
    w_busy_nxt = r_busy;
    for (int p = 0; p < int'(NWR); p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
        w_regs_nxt[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
        w_busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end
    w_regs_nxt[0] = '0;
    w_busy_nxt[0] = 1'b0;
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  assign w_src_regs = w_regs_nxt;
  assign w_src_busy = w_busy_nxt;
`else
  assign w_src_regs = r_regs;
  assign w_src_busy = r_busy;
`endif

  // Architectural state and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      r_regs <= w_regs_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // Registered read ports; data/busy hold when no request is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_rd_busy  <= '0;
    end else begin
      for (int r = 0; r < int'(NRD); r++) begin
        r_rd_valid[r] <= rd_req[r];
        if (rd_req[r]) begin
          r_rd_data[r*XLEN +: XLEN] <= w_src_regs[rd_addr[r*AW +: AW]];
          r_rd_busy[r]              <= w_src_busy[rd_addr[r*AW +: AW]];
        end
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_busy  = r_rd_busy;
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp, built with two write and three read ports.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 3;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = 5;

  logic                 clk;
  logic                 rst_n;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic [NRD-1:0]       rd_req;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_valid;
  logic [NRD-1:0]       rd_busy;
  logic [NREGS-1:0]     busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_busy  (rd_busy),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    rd_req   = '0;
    rd_addr  = '0;
  endtask

  // Apply the current inputs at one rising edge, then return just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p]               = 1'b1;
    wr_addr[p*AW +: AW]    = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int r, input logic [AW-1:0] a);
    rd_req[r]           = 1'b1;
    rd_addr[r*AW +: AW] = a;
  endtask

  logic [XLEN-1:0] exp_coll;
  logic            exp_rsv_busy;

  initial begin
    idle();
    rst_n = 1'b1;
    // Asynchronous reset with no clock edge yet.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("rst_rd_data",  64'(rd_data[XLEN-1:0]), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // All registers read back zero and not busy after reset.
    for (int i = 1; i < 32; i++) begin
      idle();
      rd(0, AW'(i));
      tick();
      chk("rst_rd_loop_data", 64'(rd_data[0 +: XLEN]), 64'h0);
      chk("rst_rd_loop_busy", 64'(rd_busy[0]), 64'h0);
    end
    chk("rst_rd_loop_valid", 64'(rd_valid[0]), 64'h1);

    // Reset mid-operation drops the in-flight read.
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rd_valid), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 64'(rd_valid), 64'h0);

    // Basic write then read.
    idle(); wr(0, 5'd5, 32'hDEADBEEF); tick();
    idle(); rd(0, 5'd5); tick();
    chk("basic_valid", 64'(rd_valid), 64'h1);
    chk("basic_data",  64'(rd_data[0 +: XLEN]), 64'hDEADBEEF);
    chk("basic_busy",  64'(rd_busy[0]), 64'h0);

    // Register zero ignores writes and reservations.
    idle(); wr(0, 5'd0, 32'h12345678); rsv_en = 1'b1; rsv_addr = 5'd0; tick();
    chk("r0_busy_vec", 64'(busy_vec), 64'h0);
    idle(); rd(0, 5'd0); tick();
    chk("r0_data", 64'(rd_data[0 +: XLEN]), 64'h0);
    chk("r0_busy", 64'(rd_busy[0]), 64'h0);

    // Scoreboard: reserve, read busy, clear by writeback, reserve+write.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd7; tick();
    chk("sb_rsv_vec", 64'(busy_vec), 64'h80);
    idle(); rd(1, 5'd7); tick();
    chk("sb_rd_busy",  64'(rd_busy), 64'h2);
    chk("sb_rd_valid", 64'(rd_valid), 64'h2);
    idle(); wr(0, 5'd7, 32'hA5); tick();
    chk("sb_wb_vec", 64'(busy_vec), 64'h0);
    idle(); wr(1, 5'd7, 32'h5A); rsv_en = 1'b1; rsv_addr = 5'd7; tick();
    chk("sb_rsvwr_vec", 64'(busy_vec), 64'h80);
    idle(); rd(2, 5'd7); tick();
    chk("sb_rsvwr_data", 64'(rd_data[2*XLEN +: XLEN]), 64'h5A);
    chk("sb_rsvwr_busy", 64'(rd_busy[2]), 64'h1);
    // Held outputs when no request is sampled.
    idle(); tick();
    chk("hold_valid", 64'(rd_valid), 64'h0);
    chk("hold_data",  64'(rd_data[2*XLEN +: XLEN]), 64'h5A);
    chk("hold_busy",  64'(rd_busy[2]), 64'h1);

    // Read/write collision on reg9.
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_coll     = 32'h2;
    exp_rsv_busy = 1'b1;
`else
    exp_coll     = 32'h1;
    exp_rsv_busy = 1'b0;
`endif
    idle(); wr(0, 5'd9, 32'h1); tick();
    idle(); wr(0, 5'd9, 32'h2); rd(0, 5'd9); tick();
    chk("coll_data", 64'(rd_data[0 +: XLEN]), 64'(exp_coll));
    chk("coll_busy", 64'(rd_busy[0]), 64'h0);
    idle(); rsv_en = 1'b1; rsv_addr = 5'd9; rd(0, 5'd9); tick();
    chk("coll_rsv_busy", 64'(rd_busy[0]), 64'(exp_rsv_busy));
    chk("coll_rsv_data", 64'(rd_data[0 +: XLEN]), 64'h2);

    // Multi-port writes: same register from both ports, highest port wins.
    idle(); wr(0, 5'd31, 32'hCAFEF00D); tick();
    idle(); wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); tick();
    idle(); rd(0, 5'd3); rd(1, 5'd0); rd(2, 5'd31); tick();
    chk("mp_valid", 64'(rd_valid), 64'h7);
    chk("mp_data0", 64'(rd_data[0 +: XLEN]), 64'h22);
    chk("mp_data1", 64'(rd_data[XLEN +: XLEN]), 64'h0);
    chk("mp_data2", 64'(rd_data[2*XLEN +: XLEN]), 64'hCAFEF00D);
    chk("mp_busy",  64'(rd_busy), 64'h0);
    chk("mp_vec",   64'(busy_vec), 64'h280);

    // Two ports writing different registers in one cycle.
    idle(); wr(0, 5'd10, 32'hAAAA0001); wr(1, 5'd11, 32'hBBBB0002);
    rsv_en = 1'b1; rsv_addr = 5'd12; tick();
    idle(); rd(0, 5'd11); rd(1, 5'd10); rd(2, 5'd12); tick();
    chk("mp2_data0", 64'(rd_data[0 +: XLEN]), 64'hBBBB0002);
    chk("mp2_data1", 64'(rd_data[XLEN +: XLEN]), 64'hAAAA0001);
    chk("mp2_busy",  64'(rd_busy), 64'h4);
    chk("mp2_vec",   64'(busy_vec), 64'h1280);

    idle(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file that succeeds the single-write, dual-read regfile.
- Read ports are registered, with one-cycle latency and a per-port valid. Write port count is configurable.
- A per-register busy scoreboard is set when an instruction reserves its destination and cleared when that destination is written back.
- Sits between decode/issue (reservation, operand reads) and writeback (writes) of the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >=2. Register 0 is hardwired to zero.
- NRD, 2, number of read ports, >=1.
- NWR, 1, number of write ports, >=1.
- Localparam AW = $clog2(NREGS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write register index; port p occupies bits [p*AW +: AW].
- wr_data  in  NWR*XLEN  write data; port p occupies bits [p*XLEN +: XLEN].
- rsv_en  in  1  reserve destination (set busy).
- rsv_addr  in  AW  register to reserve.
- rd_req  in  NRD  per-port read request.
- rd_addr  in  NRD*AW  read register index per port.
- rd_data  out  NRD*XLEN  registered read data.
- rd_valid  out  NRD  rd_data/rd_busy for that port are valid this cycle.
- rd_busy  out  NRD  the read register had a pending producer.
- busy_vec  out  NREGS  live scoreboard, bit i = register i busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0, all busy bits = 0;
  - rd_data = 0, rd_valid = 0, rd_busy = 0.
  - Reset asserted mid-operation discards any in-flight read: rd_valid = 0 on the cycle following deassertion unless a new rd_req is sampled.
- Writes: at each edge, for each p with wr_en[p] and wr_addr[p] != 0, reg[wr_addr[p]] <= wr_data[p] and busy[wr_addr[p]] <= 0.
  - If several ports write the same register, the highest port index wins for data.
  - Writes to register 0 are ignored; reg0 and busy[0] are always 0.
- Reserve: rsv_en with rsv_addr != 0 sets busy[rsv_addr] <= 1. Reserve of 0 is ignored.
  - If reserve and write hit the same register in the same cycle, data is written and busy ends at 1: the reservation belongs to a newer producer.
- Reads: rd_req[r] sampled at edge N gives at edge N+1:
  - rd_valid[r] = 1;
  - rd_data[r] = value of reg[rd_addr[r]];
  - rd_busy[r] = busy bit; address 0 always returns data 0, busy 0.
  - Without rd_req, rd_valid[r] = 0 and rd_data/rd_busy hold their previous values.
- Read/write collision in the same sampling cycle is governed by WRITE_BYPASS_EN (below).
- busy_vec reflects the registered scoreboard (post-edge state); it is not bypassed.
- No backpressure: every request completes in exactly one cycle.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined (write-first): a read sampled in the same cycle as a write or reserve to the same register returns next-state values.
  - rd_data = the winning write data (highest port index);
  - rd_busy = 0 if written and not reserved, 1 if reserved.
- Undefined (read-first): the read returns pre-edge values, i.e. old data and old busy bit.

Test Plan:
- Reset: pulse rst_n low asynchronously, no clock edge -> busy_vec = 0, rd_valid = 0. Then read regs 1..31 -> all data 0, busy 0.
- Basic write/read: write reg5 = 0xDEADBEEF, next cycle rd_req port0 addr5 -> one cycle later rd_valid[0] = 1, rd_data = 0xDEADBEEF, rd_busy = 0.
- Register zero: write reg0 = 0x12345678 and reserve reg0 -> read reg0 returns 0, busy 0; busy_vec[0] stays 0.
- Scoreboard:
  - reserve reg7 -> busy_vec[7] = 1; read reg7 -> rd_busy = 1.
  - write reg7 = 0xA5 -> busy_vec[7] = 0.
  - same cycle reserve+write reg7 = 0x5A -> data 0x5A, busy_vec[7] = 1.
- Collision: reg9 = 0x1, then same cycle write reg9 = 0x2 and read reg9 -> bypass build returns 0x2 busy 0; non-bypass build returns 0x1.
- Multi-port (NWR=2, NRD=3): ports 0/1 write reg3 = 0x11/0x22 together -> reg3 = 0x22. Three simultaneous reads of reg3, reg0, reg31 -> 0x22, 0, correct value, all rd_valid = 1.
